// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, fetch FSM encoding and opcode field position
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 8;
  localparam int FETCH_INSTR_W = 16;

  // Opcode field of an instruction word
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 3;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [FETCH_INSTR_W-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - 2-entry {pc, instr} buffer with push/pop/flush and occupancy count
module fetch_fifo import fetch_pkg::*; #(
  parameter int ADDR_W  = FETCH_ADDR_W,
  parameter int INSTR_W = FETCH_INSTR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic [1:0]         count
);

  logic [ADDR_W-1:0]  pc_mem    [2];
  logic [INSTR_W-1:0] instr_mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic               do_push;
  logic               do_pop;

  // Never overrun or underrun, even if the caller misbehaves
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  // Storage, pointers and count; flush only empties, entries are not cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        pc_mem[wr_ptr]    <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr            <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC/fetch FSM feeding a 2-entry buffer; FETCH_HALT_EN enables halt on all-zero word
module instr_fetch import fetch_pkg::*; #(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(8'h00)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic [INSTR_W-1:0] instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               halted
);

  logic [ADDR_W-1:0] pc;
  fetch_state_e      state;
  logic [1:0]        count;
  logic              pop;
  logic              fetch_slot;
  logic              end_hit;
  logic              push;

  assign instr_addr = pc;
  assign if_valid   = (count != 2'd0);

  // Redirect wins over everything: no pop and no push in that cycle
  assign pop        = if_valid && if_ready && !redirect_valid;
  assign fetch_slot = (state == ST_RUN) && !redirect_valid &&
                      ((count != 2'd2) || pop);

`ifdef FETCH_HALT_EN
  assign end_hit = fetch_slot && (instr == '0);
`else
  assign end_hit = 1'b0;
`endif

  assign push = fetch_slot && !end_hit;

  fetch_fifo #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_pc    (pc),
    .push_instr (instr),
    .head_pc    (if_pc),
    .head_instr (if_instr),
    .count      (count)
  );

  // PC and RUN/HALT state; PC wraps naturally at 2^ADDR_W
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= ST_RUN;
    end else if (redirect_valid) begin
      pc    <= redirect_addr;
      state <= ST_RUN;
    end else if (push) begin
      pc <= pc + 1'b1;
    end else if (end_hit) begin
      state <= ST_HALT;
    end
  end

`ifdef FETCH_HALT_EN
  logic halted_q;

  // halted tracks entry into and exit from HALT as a registered flag
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (redirect_valid) begin
      halted_q <= 1'b0;
    end else if (end_hit) begin
      halted_q <= 1'b1;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized and directed checks of instr_fetch against a queue model
module tb_instr_fetch;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [ADDR_W-1:0]  instr_addr;
  logic [INSTR_W-1:0] instr;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_addr;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               halted;

  logic [INSTR_W-1:0] rom [256];
  assign instr = rom[instr_addr];

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .instr_addr     (instr_addr),
    .instr          (instr),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched {pc, instr} words plus PC and halt flag
  logic [ADDR_W+INSTR_W-1:0] mq [$];
  logic [ADDR_W-1:0]         m_pc;
  bit                        m_halt;

  always @(posedge clk) begin
    bit pop_now;
    bit slot;
    if (rst) begin
      mq.delete();
      m_pc   = 8'h00;
      m_halt = 1'b0;
      chk_en = 1'b1;
    end else if (redirect_valid) begin
      mq.delete();
      m_pc   = redirect_addr;
      m_halt = 1'b0;
    end else begin
      pop_now = (mq.size() > 0) && if_ready;
      slot    = !m_halt && ((mq.size() < 2) || pop_now);
      if (pop_now) void'(mq.pop_front());
      if (slot) begin
        if (HALT_EN && rom[m_pc] == 16'h0000) begin
          m_halt = 1'b1;
        end else begin
          mq.push_back({m_pc, rom[m_pc]});
          m_pc = m_pc + 8'd1;
        end
      end
    end
  end

  // Compare process: every cycle once the model has been reset
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_valid", {31'd0, if_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
        check("model_pc", {24'd0, if_pc}, {24'd0, mq[0][ADDR_W+INSTR_W-1:INSTR_W]});
        check("model_instr", {16'd0, if_instr}, {16'd0, mq[0][INSTR_W-1:0]});
      end
      check("model_addr", {24'd0, instr_addr}, {24'd0, m_pc});
      check("model_halted", {31'd0, halted}, {31'd0, m_halt});
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic ready);
    rst = 1'b1;
    redirect_valid = 1'b0;
    if_ready = ready;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic redirect_to(input logic [ADDR_W-1:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom_range(1, 16'hFFFF));
    rom[0] = 16'h2200;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    if_ready = 1'b0;

    // Reset state, then first word one cycle after release
    step();
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", {16'd0, if_instr}, 32'd0);
    check("rst_pc", {24'd0, if_pc}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    if_ready = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("first_valid", {31'd0, if_valid}, 32'd1);
    check("first_instr", {16'd0, if_instr}, 32'h2200);

    // Streaming with if_ready high: no bubbles
    for (int i = 0; i <= 12; i++) begin
      check($sformatf("stream_pc%0d", i), {24'd0, if_pc}, i);
      check("stream_valid", {31'd0, if_valid}, 32'd1);
      step();
    end

    // Backpressure: buffer fills at 2, PC holds at 2
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step();
    check("bp_addr", {24'd0, instr_addr}, 32'd2);
    check("bp_pc", {24'd0, if_pc}, 32'd0);
    if_ready = 1'b1;
    for (int i = 0; i <= 2; i++) begin
      check($sformatf("bp_order%0d", i), {24'd0, if_pc}, i);
      step();
    end

    // Redirect while full: bubble, then target, old entries dropped
    if_ready = 1'b0;
    step();
    step();
    if_ready = 1'b1;
    redirect_to(8'h09);
    check("redir_bubble", {31'd0, if_valid}, 32'd0);
    step();
    check("redir_pc", {24'd0, if_pc}, 32'h09);
    check("redir_instr", {16'd0, if_instr}, {16'd0, rom[9]});
    step();
    check("redir_next", {24'd0, if_pc}, 32'h0A);

    // Wrap past the top of the address space
    redirect_to(8'hFE);
    check("wrap_bubble", {31'd0, if_valid}, 32'd0);
    step();
    check("wrap_fe", {24'd0, if_pc}, 32'hFE);
    step();
    check("wrap_ff", {24'd0, if_pc}, 32'hFF);
    step();
    check("wrap_00", {24'd0, if_pc}, 32'h00);
    step();
    check("wrap_01", {24'd0, if_pc}, 32'h01);

`ifdef FETCH_HALT_EN
    // End-of-program word stops fetch; redirect restarts it
    rom[13] = 16'h0000;
    do_reset(1'b1);
    for (int i = 0; i <= 12; i++) begin
      check($sformatf("halt_pc%0d", i), {24'd0, if_pc}, i);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      check("halt_flag", {31'd0, halted}, 32'd1);
      check("halt_addr", {24'd0, instr_addr}, 32'd13);
      check("halt_novalid", {31'd0, if_valid}, 32'd0);
      step();
    end
    redirect_to(8'h00);
    check("unhalt_flag", {31'd0, halted}, 32'd0);
    step();
    check("unhalt_pc", {24'd0, if_pc}, 32'd0);
    rom[13] = 16'h1234;
`endif

    // Random phase: ROM with a few zero words, random handshake, redirects and resets
    for (int i = 0; i < 8; i++) rom[$urandom_range(0, 255)] = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 99) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_addr  = 8'($urandom_range(0, 255));
      if_ready       = ($urandom_range(0, 3) != 0);
      step();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
